// File: rtl/transmision_dac.sv
// transmision_dac: serial transmitter for a DAC121S101-class 12-bit DAC.
// Shifts a 16-bit frame {2'b00, pd_mode, sample} out MSB first on DIN,
// framed by an active-low SYNC and clocked by SCLK (idles high).
// Optional macro DAC_SIGNED_EN: treat data_in as two's complement and
// convert it to offset binary by inverting bit 11 before transmission.
module transmision_dac #(
  parameter int CLK_DIV = 4,
  parameter int QUIET   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pd_mode,
  input  logic [11:0] data_in,
  output logic        SCLK,
  output logic        SYNC,
  output logic        DIN,
  output logic        busy,
  output logic        tx_done_tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int QW = $clog2(QUIET + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [15:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          sync_q, sync_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   frame;

`ifdef DAC_SIGNED_EN
  assign frame = {2'b00, pd_mode, ~data_in[11], data_in[10:0]};
`else
  assign frame = {2'b00, pd_mode, data_in};
`endif

  // Next-state logic: DIN is the shift register MSB, cleared outside SHIFT
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          shift_d = frame;
          div_d   = '0;
          bit_d   = '0;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == 4'd15) begin
            state_d = S_QUIET;
            quiet_d = '0;
            shift_d = '0;
            sclk_d  = 1'b1;
            sync_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = S_IDLE;
          quiet_d = '0;
          busy_d  = 1'b0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = '0;
        sclk_d  = 1'b1;
        sync_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset aborts any frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SCLK         = sclk_q;
  assign SYNC         = sync_q;
  assign DIN          = shift_q[15];
  assign busy         = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_transmision_dac.sv
// Testbench for transmision_dac: table-driven frames plus hand-written
// sequences for reset, mid-frame abort and back-to-back operation.
module tb_transmision_dac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pd_mode = 2'b00;
  logic [11:0] data_in = 12'h000;
  logic        SCLK, SYNC, DIN, busy, tx_done_tick;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  pd;
    logic [11:0] data;
    logic [15:0] expFrame;
    bit          disturb;
  } vec_t;

  vec_t vecs[5];

  transmision_dac #(.CLK_DIV(4), .QUIET(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pd_mode(pd_mode),
    .data_in(data_in), .SCLK(SCLK), .SYNC(SYNC), .DIN(DIN),
    .busy(busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  // Drive inputs, step one clock, and sample 1 time unit after the edge
  task automatic applyStimulus(input logic st, input logic [1:0] pd,
                               input logic [11:0] d, input logic rst);
    start   = st;
    pd_mode = pd;
    data_in = d;
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One complete frame with bit capture on SCLK falling edges
  task automatic runFrame(input vec_t v, input string tag);
    int lowCyc = 0, falls = 0, doneCnt = 0, busyDly = 0, extra = 0;
    logic [15:0] cap = '0;
    logic prevSclk = 1'b1;
    logic [11:0] curData = v.data;
    logic nextStart;
    bit rose = 0, finished = 0;
    applyStimulus(1'b1, v.pd, v.data, 1'b0);
    checkOutput({tag, "_startSyncBusy"}, {30'd0, SYNC, busy}, 32'b01);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!SYNC) lowCyc++;
      if (prevSclk && !SCLK && !SYNC) begin
        cap = {cap[14:0], DIN};
        falls++;
      end
      if (tx_done_tick) doneCnt++;
      if (!rose && SYNC) begin
        rose = 1;
        checkOutput({tag, "_doneAtRise"}, {31'd0, tx_done_tick}, 32'd1);
      end
      if (rose && busy) busyDly++;
      if (rose && !busy) begin
        finished = 1;
        break;
      end
      prevSclk = SCLK;
      nextStart = 1'b0;
      if (v.disturb && (lowCyc == 40 || busyDly == 3)) begin
        nextStart = 1'b1;
        curData = 12'h123;
      end
      applyStimulus(nextStart, v.pd, curData, 1'b0);
    end
    checkOutput({tag, "_finished"}, {31'd0, finished}, 32'd1);
    checkOutput({tag, "_frame"}, {16'd0, cap}, {16'd0, v.expFrame});
    checkOutput({tag, "_falls"}, falls, 16);
    checkOutput({tag, "_syncLow"}, lowCyc, 128);
    checkOutput({tag, "_doneCount"}, doneCnt, 1);
    checkOutput({tag, "_busyDelay"}, busyDly, 8);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, v.pd, curData, 1'b0);
      if (!SYNC || busy || tx_done_tick) extra++;
    end
    checkOutput({tag, "_noExtraFrame"}, extra, 0);
  endtask

  initial begin
    int falls, gap, dones;
    logic prevSclk;
    bit seen;

`ifdef DAC_SIGNED_EN
    vecs[0] = '{2'b00, 12'hA5C, 16'h025C, 1'b0};
    vecs[1] = '{2'b11, 12'hFFF, 16'h37FF, 1'b0};
    vecs[2] = '{2'b00, 12'h800, 16'h0000, 1'b0};
    vecs[3] = '{2'b00, 12'h7FF, 16'h0FFF, 1'b0};
    vecs[4] = '{2'b00, 12'hA5C, 16'h025C, 1'b1};
`else
    vecs[0] = '{2'b00, 12'hA5C, 16'h0A5C, 1'b0};
    vecs[1] = '{2'b11, 12'hFFF, 16'h3FFF, 1'b0};
    vecs[2] = '{2'b00, 12'h800, 16'h0800, 1'b0};
    vecs[3] = '{2'b01, 12'h3C3, 16'h13C3, 1'b0};
    vecs[4] = '{2'b00, 12'hA5C, 16'h0A5C, 1'b1};
`endif

    // Reset held with start high: outputs at reset values, no frame
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 12'hA5C, 1'b1);
      checkOutput($sformatf("resetHold%0d", i),
                  {27'd0, SCLK, SYNC, DIN, busy, tx_done_tick}, 32'b11000);
    end
    applyStimulus(1'b0, 2'b00, 12'h000, 1'b0);
    checkOutput("resetRelease",
                {27'd0, SCLK, SYNC, DIN, busy, tx_done_tick}, 32'b11000);

    for (int i = 0; i < 5; i++) runFrame(vecs[i], $sformatf("vec%0d", i));

    // Reset after 7 falling edges aborts the frame without a done tick
    applyStimulus(1'b1, 2'b00, 12'h555, 1'b0);
    falls = 0;
    prevSclk = 1'b1;
    for (int cyc = 0; cyc < 500 && falls < 7; cyc++) begin
      if (prevSclk && !SCLK && !SYNC) falls++;
      prevSclk = SCLK;
      if (falls < 7) applyStimulus(1'b0, 2'b00, 12'h555, 1'b0);
    end
    checkOutput("abortReachedFalls", falls, 7);
    applyStimulus(1'b0, 2'b00, 12'h555, 1'b1);
    checkOutput("abortResetValues",
                {27'd0, SCLK, SYNC, DIN, busy, tx_done_tick}, 32'b11000);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 2'b00, 12'h555, 1'b0);
      if (tx_done_tick || !SYNC || busy) dones++;
    end
    checkOutput("abortQuiet", dones, 0);
    runFrame('{2'b00, 12'h001, 16'h0001, 1'b0}, "afterAbort");

    // Start held high: SYNC-high gap between consecutive frames
    seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(1'b1, 2'b00, 12'hA5C, 1'b0);
      if (!SYNC) begin
        seen = 1;
        break;
      end
    end
    checkOutput("b2bFirstStart", {31'd0, seen}, 32'd1);
    seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(1'b1, 2'b00, 12'hA5C, 1'b0);
      if (SYNC) begin
        seen = 1;
        break;
      end
    end
    checkOutput("b2bFirstEnd", {31'd0, seen}, 32'd1);
    gap = 0;
    for (int cyc = 0; cyc < 50 && SYNC; cyc++) begin
      gap++;
      applyStimulus(1'b1, 2'b00, 12'hA5C, 1'b0);
    end
    checkOutput("b2bGap", gap, 9);
    seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(1'b0, 2'b00, 12'hA5C, 1'b0);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    checkOutput("b2bDrain", {31'd0, seen}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transmision_dac.md
# transmision_dac

- Serial transmitter for a DAC121S101-class 12-bit DAC.
- Takes a 12-bit sample and a 2-bit power-down mode on a single-cycle start strobe.
- Generates SYNC, SCLK and DIN from the system clock and shifts a 16-bit frame out MSB first, with a done tick and a busy flag.
- It is the outbound counterpart of the ADC receive path: the same interface style, driven instead of received. It sits between the processing datapath and the DAC pins.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- QUIET, 8, clk cycles SYNC is held high after a frame before a new start is accepted (≥1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a frame; sampled only in IDLE
- pd_mode  input  2  DAC power-down bits, latched on start
- data_in  input  12  sample, latched on start
- SCLK  output  1  serial clock to DAC, idles high
- SYNC  output  1  frame select, active low
- DIN  output  1  serial data to DAC
- busy  output  1  high whenever the FSM is not in IDLE
- tx_done_tick  output  1  one-cycle pulse at frame end

All outputs are registered. Reset values: SCLK=1, SYNC=1, DIN=0, busy=0, tx_done_tick=0. FSM resets to IDLE; all counters reset to 0.

## Operation
- Frame layout, bit 15 first: {2'b00, pd_mode, data_in}. Example: pd_mode=00, data_in=0xA5C gives frame 0x0A5C.
- FSM states: IDLE, SHIFT, QUIET.
- IDLE:
  - Outputs are at reset values.
  - start=1 latches the frame into a 16-bit shift register, clears div_cnt and bit_cnt, and moves to SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; SCLK toggles when div_cnt=CLK_DIV-1.
  - On entry: SYNC=0, SCLK=1, DIN=frame[15].
  - The DAC samples DIN on each SCLK falling edge.
  - On each SCLK rising toggle, DIN advances to the next bit and bit_cnt increments.
  - At the end of the 16th SCLK low phase, the FSM moves to QUIET.
- QUIET:
  - SYNC=1, SCLK=1, DIN=0.
  - tx_done_tick=1 on the first QUIET cycle only.
  - Stays QUIET cycles, then returns to IDLE.
- data_in and pd_mode are ignored outside the start-accept cycle; changes mid-frame have no effect.
- start in SHIFT or QUIET is ignored and not queued.
- reset in any state forces reset values on the next edge and aborts the frame. No tx_done_tick is produced for an aborted frame.
- reset and start in the same cycle: reset wins.

## Timing
- start sampled high in IDLE at edge k: SYNC falls and busy rises at edge k+1.
- SYNC is low for exactly 32·CLK_DIV clk cycles (128 at the default).
- SCLK high and low phases are each CLK_DIV cycles. DIN is stable for CLK_DIV cycles before and after every falling edge.
- Exactly 16 SCLK falling edges occur per frame.
- tx_done_tick is high in the same cycle SYNC returns high.
- busy falls QUIET cycles after SYNC rises.
- With start held high continuously, consecutive frames are separated by QUIET+1 cycles of SYNC high.

## Configuration
- Macro: DAC_SIGNED_EN.
- Defined: data_in is two's complement. The frame uses {data_in[11] inverted, data_in[10:0]}, converting it to the offset binary the DAC expects.
- Undefined: data_in is straight binary and is sent unchanged.
- The macro changes nothing else: timing and ports are identical either way.

## Test plan
- Reset check:
  - Stimulus: reset held 3 cycles with start=1.
  - Required: SCLK=1, SYNC=1, DIN=0, busy=0, tx_done_tick=0, and no frame starts.
- Basic frame:
  - Stimulus: defaults, pd_mode=00, data_in=0xA5C, one-cycle start.
  - Required: bits sampled on SCLK falling edges equal 0x0A5C; SYNC low exactly 128 cycles; exactly one tx_done_tick in the cycle SYNC rises; busy low 8 cycles later.
- Power-down bits:
  - Stimulus: pd_mode=11, data_in=0xFFF.
  - Required: captured frame is 0x3FFF.
- Ignored inputs:
  - Stimulus: start pulsed and data_in changed to 0x123 during SHIFT and during QUIET.
  - Required: the original frame is unaffected; no extra frame follows; busy falls on schedule.
- Reset mid-frame:
  - Stimulus: reset asserted after 7 falling edges.
  - Required: reset values appear at the next edge with no tx_done_tick; a following start with data_in=0x001 yields a clean 16-bit frame 0x0001.
- Configuration and back-to-back:
  - Stimulus (DAC_SIGNED_EN defined): data_in=0x800.
  - Required: frame 0x0000.
  - Stimulus (DAC_SIGNED_EN defined): data_in=0x7FF.
  - Required: frame 0x0FFF.
  - Stimulus (DAC_SIGNED_EN undefined): data_in=0x800.
  - Required: frame 0x0800.
  - Stimulus: start held high.
  - Required: SYNC high gap between frames is 9 cycles.
